slc3_input_conditioner: RTL and testbench

Conditions the raw board inputs of the SLC-3 computer before they reach the processor core. The raw active-low Run and Continue pushbuttons are synchronized, debounced, and converted to debounced levels plus single-cycle press pulses. The 10 slide switches are synchronized. The block sits directly upstream of the core inside the SLC-3 top level; the core consumes only its outputs.

---
 rtl/lc3_io_pkg.sv | 18 +
 rtl/button_debounce.sv | 109 ++++++++++
 rtl/slc3_input_conditioner.sv | 67 ++++++
 tb/tb_slc3_input_conditioner.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_io_pkg.sv
// -----------------------------------------------------------------------------
// lc3_io_pkg
// Shared types for the SLC-3 board-input conditioning logic.
//   btn_state_t  : debounce FSM states for one pushbutton
//   SYNC_STAGES  : depth of every clock-domain-crossing synchronizer
// -----------------------------------------------------------------------------
package lc3_io_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Synchronizes one raw active-low pushbutton, debounces it with a four-state
// FSM and produces a debounced active-high level plus a one-cycle press pulse.
// Ports:
//   clk_i      : system clock
//   rst_ni     : asynchronous active-low reset
//   btn_raw_i  : raw button, active-low, asynchronous to clk_i
//   level_o    : debounced level, 1 = pressed
//   pulse_o    : registered strobe, one cycle per accepted press
// -----------------------------------------------------------------------------
module button_debounce
    import lc3_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_raw_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pressed;
    btn_state_t             state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   pulse_q, pulse_d;

    // Synchronizer resets to all-ones (released) so reset never looks like a press.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw_i};
        end
    end

    assign pressed = ~sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            count_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pulse_q <= pulse_d;
        end
    end

    // count_q holds the number of qualifying samples already seen in the wait
    // state, so the DEBOUNCE_CYCLES-th sample arrives while count_q == CNT_LAST.
    // The increment saturates at all-ones instead of wrapping.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_WAIT;
                    count_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (count_q >= CNT_LAST) begin
                    state_d = PRESSED;
                    count_d = '0;
                    pulse_d = 1'b1;
                end else begin
                    count_d = (count_q == '1) ? count_q : count_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!pressed) begin
                    state_d = RELEASE_WAIT;
                    count_d = '0;
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_d = PRESSED;
                    count_d = '0;
                end else if (count_q >= CNT_LAST) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    count_d = (count_q == '1) ? count_q : count_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    assign level_o = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    assign pulse_o = pulse_q;

endmodule

// File: rtl/slc3_input_conditioner.sv
// -----------------------------------------------------------------------------
// slc3_input_conditioner
// Conditions the raw SLC-3 board inputs before they reach the processor core.
// Ports:
//   Clk             : system clock (50 MHz)
//   Reset           : asynchronous active-low reset
//   Run_raw         : raw Run button, active-low, asynchronous
//   Continue_raw    : raw Continue button, active-low, asynchronous
//   SW_raw          : raw slide switches, asynchronous
//   Run_level       : debounced Run, 1 = pressed
//   Run_pulse       : one-cycle strobe per accepted Run press
//   Continue_level  : debounced Continue, 1 = pressed
//   Continue_pulse  : one-cycle strobe per accepted Continue press
//   SW_sync         : synchronized switches (no debounce)
// -----------------------------------------------------------------------------
module slc3_input_conditioner
    import lc3_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SW_WIDTH        = 10
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Run_raw,
    input  logic                Continue_raw,
    input  logic [SW_WIDTH-1:0] SW_raw,
    output logic                Run_level,
    output logic                Run_pulse,
    output logic                Continue_level,
    output logic                Continue_pulse,
    output logic [SW_WIDTH-1:0] SW_sync
);

    logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] swSync_q;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) runDebounce (
        .clk_i    (Clk),
        .rst_ni   (Reset),
        .btn_raw_i(Run_raw),
        .level_o  (Run_level),
        .pulse_o  (Run_pulse)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) continueDebounce (
        .clk_i    (Clk),
        .rst_ni   (Reset),
        .btn_raw_i(Continue_raw),
        .level_o  (Continue_level),
        .pulse_o  (Continue_pulse)
    );

    // Switches are level inputs the core only reads, so a plain synchronizer suffices.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            swSync_q <= '0;
        end else begin
            swSync_q <= {swSync_q[SYNC_STAGES-2:0], SW_raw};
        end
    end

    assign SW_sync = swSync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_slc3_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_slc3_input_conditioner
// Self-checking bench for slc3_input_conditioner with DEBOUNCE_CYCLES = 4.
// A cycle-level hysteresis model predicts every output; predictions are queued
// when stimulus is driven and compared once the clock edge has produced them.
// Segment tables and hand-written sequences add fixed, hand-derived checks.
// -----------------------------------------------------------------------------
module tb_slc3_input_conditioner;

   localparam int DEB = 4;
   localparam int SWW = 10;

   logic           Clk = 1'b0;
   logic           Reset = 1'b0;
   logic           Run_raw = 1'b1;
   logic           Continue_raw = 1'b1;
   logic [SWW-1:0] SW_raw = '0;
   logic           Run_level, Run_pulse, Continue_level, Continue_pulse;
   logic [SWW-1:0] SW_sync;

   slc3_input_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .SW_WIDTH(SWW)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .Run_raw(Run_raw),
      .Continue_raw(Continue_raw),
      .SW_raw(SW_raw),
      .Run_level(Run_level),
      .Run_pulse(Run_pulse),
      .Continue_level(Continue_level),
      .Continue_pulse(Continue_pulse),
      .SW_sync(SW_sync)
   );

   // 100 MHz is irrelevant here; only edge counts matter
   always #5 Clk = ~Clk;

   typedef struct {
      logic           runLevel;
      logic           runPulse;
      logic           contLevel;
      logic           contPulse;
      logic [SWW-1:0] sw;
   } expect_t;

   typedef struct {
      logic           run;
      logic           cont;
      logic [SWW-1:0] sw;
      int             n;
      logic           eRunLevel;
      int             eRunPulses;
      logic           eContLevel;
      int             eContPulses;
      logic [SWW-1:0] eSw;
   } vec_t;

   expect_t sbQueue[$];
   vec_t    vecs[$];

   int errors = 0;
   int checks = 0;
   int cycleNo = 0;
   int segRunPulses = 0;
   int segContPulses = 0;

   // Model state: two sample history per input, plus hysteresis per button
   logic           mRun1, mRun2, mCont1, mCont2;
   logic [SWW-1:0] mSw1, mSw2;
   logic           mRunLevel, mContLevel;
   int             mRunLen, mContLen;

   task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, cycleNo, got, want);
      end
   endtask

   task automatic modelReset();
      mRun1 = 1'b1; mRun2 = 1'b1; mCont1 = 1'b1; mCont2 = 1'b1;
      mSw1 = '0; mSw2 = '0;
      mRunLevel = 1'b0; mContLevel = 1'b0;
      mRunLen = 0; mContLen = 0;
   endtask

   // The level flips once DEB+1 consecutive synchronized samples disagree with it;
   // a press acceptance is exactly a 0->1 flip.
   task automatic stepButton(input logic rawNow, inout logic s1, inout logic s2,
                             inout logic level, inout int runLen, output logic pulse);
      logic pressedNow;
      pressedNow = ~s2;
      s2 = s1;
      s1 = rawNow;
      pulse = 1'b0;
      if (pressedNow != level) begin
         runLen++;
         if (runLen == DEB + 1) begin
            level = pressedNow;
            runLen = 0;
            pulse = pressedNow;
         end
      end else begin
         runLen = 0;
      end
   endtask

   task automatic checkOutput();
      expect_t e;
      if (sbQueue.size() == 0) begin
         checkVal("sb_empty", 32'd1, 32'd0);
         return;
      end
      e = sbQueue.pop_front();
      checkVal("Run_level", 32'(Run_level), 32'(e.runLevel));
      checkVal("Run_pulse", 32'(Run_pulse), 32'(e.runPulse));
      checkVal("Continue_level", 32'(Continue_level), 32'(e.contLevel));
      checkVal("Continue_pulse", 32'(Continue_pulse), 32'(e.contPulse));
      checkVal("SW_sync", 32'(SW_sync), 32'(e.sw));
      segRunPulses += int'(Run_pulse);
      segContPulses += int'(Continue_pulse);
   endtask

   // Drive one cycle of inputs, queue the model's prediction for the coming edge,
   // then compare 1 time unit after that edge.
   task automatic applyStimulus(input logic run, input logic cont, input logic [SWW-1:0] sw);
      expect_t e;
      logic rp, cp;
      Run_raw = run;
      Continue_raw = cont;
      SW_raw = sw;
      stepButton(run, mRun1, mRun2, mRunLevel, mRunLen, rp);
      stepButton(cont, mCont1, mCont2, mContLevel, mContLen, cp);
      mSw2 = mSw1;
      mSw1 = sw;
      e.runLevel = mRunLevel;
      e.runPulse = rp;
      e.contLevel = mContLevel;
      e.contPulse = cp;
      e.sw = mSw2;
      sbQueue.push_back(e);
      @(posedge Clk);
      #1;
      cycleNo++;
      checkOutput();
   endtask

   task automatic checkAllZero(input string tag);
      checkVal({tag, "_Run_level"}, 32'(Run_level), 32'd0);
      checkVal({tag, "_Run_pulse"}, 32'(Run_pulse), 32'd0);
      checkVal({tag, "_Continue_level"}, 32'(Continue_level), 32'd0);
      checkVal({tag, "_Continue_pulse"}, 32'(Continue_pulse), 32'd0);
      checkVal({tag, "_SW_sync"}, 32'(SW_sync), 32'd0);
   endtask

   task automatic addVec(input logic run, input logic cont, input logic [SWW-1:0] sw, input int n,
                         input logic eRl, input int eRp, input logic eCl, input int eCp,
                         input logic [SWW-1:0] eSw);
      vec_t v;
      v.run = run; v.cont = cont; v.sw = sw; v.n = n;
      v.eRunLevel = eRl; v.eRunPulses = eRp;
      v.eContLevel = eCl; v.eContPulses = eCp; v.eSw = eSw;
      vecs.push_back(v);
   endtask

   initial begin
      int runEdge, contEdge, levelEdge, fallEdge, pulseCount, runCount, contCount;

      //      run   cont  sw      n   RunLvl RunP ContLvl ContP  SW
      addVec(1'b1, 1'b1, 10'h000, 50, 1'b0, 0,   1'b0,   0,    10'h000);
      addVec(1'b1, 1'b0, 10'h000, 20, 1'b0, 0,   1'b1,   1,    10'h000);
      addVec(1'b1, 1'b1, 10'h000, 6,  1'b0, 0,   1'b1,   0,    10'h000);
      addVec(1'b1, 1'b1, 10'h000, 4,  1'b0, 0,   1'b0,   0,    10'h000);
      addVec(1'b0, 1'b1, 10'h000, 3,  1'b0, 0,   1'b0,   0,    10'h000);
      addVec(1'b1, 1'b1, 10'h000, 10, 1'b0, 0,   1'b0,   0,    10'h000);
      addVec(1'b0, 1'b1, 10'h000, 5,  1'b0, 0,   1'b0,   0,    10'h000);
      addVec(1'b1, 1'b1, 10'h000, 12, 1'b0, 1,   1'b0,   0,    10'h000);
      addVec(1'b1, 1'b0, 10'h000, 10, 1'b0, 0,   1'b1,   1,    10'h000);
      addVec(1'b1, 1'b1, 10'h000, 2,  1'b0, 0,   1'b1,   0,    10'h000);
      addVec(1'b1, 1'b0, 10'h000, 10, 1'b0, 0,   1'b1,   0,    10'h000);
      addVec(1'b1, 1'b1, 10'h000, 10, 1'b0, 0,   1'b0,   0,    10'h000);
      addVec(1'b0, 1'b0, 10'h000, 10, 1'b1, 1,   1'b1,   1,    10'h000);
      addVec(1'b1, 1'b1, 10'h000, 10, 1'b0, 0,   1'b0,   0,    10'h000);
      addVec(1'b1, 1'b1, 10'h05A, 3,  1'b0, 0,   1'b0,   0,    10'h05A);
      addVec(1'b1, 1'b1, 10'h001, 3,  1'b0, 0,   1'b0,   0,    10'h001);

      // Reset state
      modelReset();
      Reset = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      checkAllZero("reset");
      Reset = 1'b1;

      // Segment table
      foreach (vecs[i]) begin
         segRunPulses = 0;
         segContPulses = 0;
         for (int k = 0; k < vecs[i].n; k++) begin
            applyStimulus(vecs[i].run, vecs[i].cont, vecs[i].sw);
         end
         checkVal($sformatf("seg%0d_Run_level", i), 32'(Run_level), 32'(vecs[i].eRunLevel));
         checkVal($sformatf("seg%0d_Run_pulses", i), 32'(segRunPulses), 32'(vecs[i].eRunPulses));
         checkVal($sformatf("seg%0d_Continue_level", i), 32'(Continue_level), 32'(vecs[i].eContLevel));
         checkVal($sformatf("seg%0d_Continue_pulses", i), 32'(segContPulses), 32'(vecs[i].eContPulses));
         checkVal($sformatf("seg%0d_SW_sync", i), 32'(SW_sync), 32'(vecs[i].eSw));
      end

      // Continue press latency and release latency by edge number
      contEdge = -1; levelEdge = -1; pulseCount = 0;
      for (int e = 1; e <= 20; e++) begin
         applyStimulus(1'b1, 1'b0, 10'h001);
         if (Continue_pulse) begin
            pulseCount++;
            if (contEdge < 0) contEdge = e;
         end
         if (Continue_level && levelEdge < 0) levelEdge = e;
      end
      checkVal("cont_pulse_edge", 32'(contEdge), 32'd7);
      checkVal("cont_pulse_count", 32'(pulseCount), 32'd1);
      checkVal("cont_level_edge", 32'(levelEdge), 32'd7);
      fallEdge = -1;
      for (int e = 1; e <= 10; e++) begin
         applyStimulus(1'b1, 1'b1, 10'h001);
         if (!Continue_level && fallEdge < 0) fallEdge = e;
      end
      checkVal("cont_release_edge", 32'(fallEdge), 32'd7);

      // Switch latency: old value after one edge, new value after two
      applyStimulus(1'b1, 1'b1, 10'h05A);
      checkVal("sw_5A_edge1", 32'(SW_sync), 32'h001);
      applyStimulus(1'b1, 1'b1, 10'h05A);
      checkVal("sw_5A_edge2", 32'(SW_sync), 32'h05A);
      applyStimulus(1'b1, 1'b1, 10'h001);
      checkVal("sw_001_edge1", 32'(SW_sync), 32'h05A);
      applyStimulus(1'b1, 1'b1, 10'h001);
      checkVal("sw_001_edge2", 32'(SW_sync), 32'h001);

      // Simultaneous press, then reset during the pulse cycle
      runEdge = -1; contEdge = -1;
      for (int e = 1; e <= 7; e++) begin
         applyStimulus(1'b0, 1'b0, 10'h3FF);
         if (Run_pulse && runEdge < 0) runEdge = e;
         if (Continue_pulse && contEdge < 0) contEdge = e;
      end
      checkVal("sim_run_edge", 32'(runEdge), 32'd7);
      checkVal("sim_cont_edge", 32'(contEdge), 32'd7);
      #2;
      Reset = 1'b0;
      modelReset();
      #1;
      checkAllZero("rst_pulse");
      @(posedge Clk);
      @(posedge Clk);
      #1;
      Reset = 1'b1;

      // Buttons still held: reset again while in PRESS_WAIT
      runCount = 0; contCount = 0;
      for (int e = 1; e <= 4; e++) begin
         applyStimulus(1'b0, 1'b0, 10'h3FF);
         runCount += int'(Run_pulse);
         contCount += int'(Continue_pulse);
      end
      checkVal("pw_run_nopulse", 32'(runCount), 32'd0);
      checkVal("pw_cont_nopulse", 32'(contCount), 32'd0);
      #2;
      Reset = 1'b0;
      modelReset();
      #1;
      checkAllZero("rst_presswait");
      @(posedge Clk);
      @(posedge Clk);
      #1;
      Reset = 1'b1;

      // Held through reset release: one fresh pulse each after full latency
      runEdge = -1; contEdge = -1; runCount = 0; contCount = 0;
      for (int e = 1; e <= 12; e++) begin
         applyStimulus(1'b0, 1'b0, 10'h3FF);
         runCount += int'(Run_pulse);
         contCount += int'(Continue_pulse);
         if (Run_pulse && runEdge < 0) runEdge = e;
         if (Continue_pulse && contEdge < 0) contEdge = e;
      end
      checkVal("requal_run_edge", 32'(runEdge), 32'd7);
      checkVal("requal_cont_edge", 32'(contEdge), 32'd7);
      checkVal("requal_run_count", 32'(runCount), 32'd1);
      checkVal("requal_cont_count", 32'(contCount), 32'd1);

      for (int e = 1; e <= 10; e++) begin
         applyStimulus(1'b1, 1'b1, 10'h000);
      end
      checkVal("final_Run_level", 32'(Run_level), 32'd0);
      checkVal("final_Continue_level", 32'(Continue_level), 32'd0);
      checkVal("sb_drained", 32'(sbQueue.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
